// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin index arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rr_state_t;

    localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping mod n.
module rr_pick #(
    parameter int m = 3,
    parameter int n = 1 << m
) (
    input  logic [n-1:0] req,
    input  logic [m-1:0] ptr,
    output logic [m-1:0] pick,
    output logic         found
);

    logic [2*n-1:0] dbl;
    logic [n-1:0]   rot;
    logic [m-1:0]   off;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[n-1:0];
        off   = '0;
        found = |req;
        // Scan downward so the lowest set bit of the rotated vector wins.
        for (int i = n - 1; i >= 0; i--) begin
            if (rot[i]) off = i[m-1:0];
        end
        // n is a power of two, so the m-bit add wraps mod n for free.
        pick = ptr + off;
    end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter emitting the winner's binary index under val/rdy.
// Optional grant counter enabled by macro RR_ARB_GRANT_COUNT_EN.
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int m = 3,
    parameter int n = 1 << m
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [n-1:0]           req,
    output logic [m-1:0]           idx,
    output logic                   idx_val,
    input  logic                   idx_rdy,
    output logic                   dec_en,
`ifdef RR_ARB_GRANT_COUNT_EN
    output logic [GRANT_CNT_W-1:0] grant_count,
`endif
    output rr_state_t              state
);

    // Handshake: idx transfers on a cycle where idx_val & idx_rdy are both high
    // (a "fire"); once idx_val rises, idx is held stable until that fire, and
    // idx_rdy has no effect while idx_val is low.
    rr_state_t      state_q, state_d;
    logic [m-1:0]   ptr_q, ptr_d;
    logic [m-1:0]   idx_q, idx_d;
    logic [m-1:0]   pick_ptr;
    logic [m-1:0]   pick;
    logic           found;
    logic           fire;

    assign idx_val = (state_q == HOLD);
    assign idx     = idx_q;
    assign state   = state_q;
    assign fire    = idx_val & idx_rdy;
    assign dec_en  = fire;

    // On a fire the next pick already sees the advanced pointer, enabling back-to-back grants.
    assign pick_ptr = fire ? idx_q + m'(1) : ptr_q;

    rr_pick #(.m(m), .n(n)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (fire) begin
                    ptr_d = pick_ptr;
                    if (found) idx_d = pick;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RR_ARB_GRANT_COUNT_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    grant_cnt_q <= '0;
        else if (fire) grant_cnt_q <= grant_cnt_q + GRANT_CNT_W'(1);
    end

    assign grant_count = grant_cnt_q;
`endif

endmodule
